ds_sinc3_decimator: RTL

- Demodulates a 1-bit delta-sigma stream, as produced by the DAC modulator, back into multibit PCM samples.
- Uses a third-order CIC (sinc3) decimation filter with decimation ratio R = 2^DEC_LOG2.
- Serves as the on-chip loopback/self-test receiver for the modulator output, so cocotb benches can read reconstructed samples instead of integrating the pulse stream.
- Output uses a one-entry valid/ready holding register with a sticky overrun flag.

---
 rtl/ds_sinc3_decimator.sv | 94 +++++++++
 1 files changed

// File: rtl/ds_sinc3_decimator.sv
// Third-order CIC (sinc3) decimator turning a 1-bit delta-sigma stream back
// into unsigned PCM samples at 1/R of the bit rate (R = 2**DEC_LOG2).
// All integrator/comb arithmetic wraps modulo 2**OUT_BITS by design; the
// wrap cancels in the comb section, so nothing here may saturate.
// The result sits in a one-entry valid/ready holding register. If a new
// result arrives while the previous one is still unconsumed, the new one
// overwrites it and the sticky overrun flag is set.
module ds_sinc3_decimator #(
    parameter int DEC_LOG2 = 5,
    parameter int OUT_BITS = 3 * DEC_LOG2 + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic [OUT_BITS-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                overrun_clear
);

    localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;

    logic [DEC_LOG2-1:0] cnt;
    logic [OUT_BITS-1:0] i1, i2, i3;
    logic [OUT_BITS-1:0] d1, d2, d3;
    logic [OUT_BITS-1:0] c1, c2, c3;
    logic [OUT_BITS-1:0] bit_ext;
    logic                dec_evt;

    assign bit_ext = {{(OUT_BITS-1){1'b0}}, bit_in};

    // Decimation happens on the beat that carries the R-th bit of a frame.
    assign dec_evt = bit_valid && (cnt == CNT_LAST);

    // Comb chain works on i3 as it stood before this edge's integrator update.
    always_comb begin
        c1 = i3 - d1;
        c2 = c1 - d2;
        c3 = c2 - d3;
    end

    // Integrators and beat counter advance only on consumed bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            cnt <= '0;
        end else if (bit_valid) begin
            i1  <= i1 + bit_ext;
            i2  <= i2 + i1;
            i3  <= i3 + i2;
            cnt <= cnt + 1'b1;
        end
    end

    // Comb delay registers capture their inputs once per decimated output.
    always_ff @(posedge clk) begin
        if (reset) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else if (dec_evt) begin
            d1 <= i3;
            d2 <= c1;
            d3 <= c2;
        end
    end

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (dec_evt) begin
                sample       <= c3;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (dec_evt && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
